// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty sequencer and its period tick generator.
package pwm_ctrl_pkg;

  localparam int CNT_W = 29;
  localparam logic [7:0] MAX_DUTY = 8'd100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RAMP  = 2'd2
  } seq_state_e;

  // Cycles per PWM period, floored at 2 so the counter always has a wrap cycle.
  function automatic logic [CNT_W-1:0] period_count(input logic [27:0] clk_freq,
                                                    input logic [27:0] pwm_hz);
    logic [CNT_W-1:0] pc;
    pc = CNT_W'(clk_freq / pwm_hz);
    if (pc < CNT_W'(2)) pc = CNT_W'(2);
    return pc;
  endfunction

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Command channel into the duty sequencer.
// Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready; the
// requester holds cmd_valid, cmd_target and cmd_immediate stable until that edge.
interface pwm_duty_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_target;
  logic       cmd_immediate;

  modport master (output cmd_valid, output cmd_target, output cmd_immediate, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, input cmd_immediate, output cmd_ready);
endinterface

// File: rtl/period_tick_gen.sv
// PWM period counter (1..PERIOD_COUNT) with a registered pulse on the last cycle of each period.
module period_tick_gen
  import pwm_ctrl_pkg::*;
#(
  parameter logic [27:0] CLK_FREQ = 28'd100_000000,
  parameter logic [27:0] PWM_HZ   = 28'd1000
) (
  input  logic sys_clk_in,
  input  logic reset,
  output logic period_start
);

  localparam logic [CNT_W-1:0] PERIOD_COUNT = period_count(CLK_FREQ, PWM_HZ);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt_q == PERIOD_COUNT) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  end

  // The pulse is registered from the next count so it is high exactly while cnt_q == PERIOD_COUNT.
  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      cnt_q        <= CNT_W'(1);
      period_start <= 1'b0;
    end else begin
      cnt_q        <= cnt_next;
      period_start <= (cnt_next == PERIOD_COUNT);
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty sequencer: applies jump or 1%-ramp duty commands only at PWM period boundaries.
// Optional feature macro: DUTY_CLAMP_EN (clamp targets above 100 instead of rejecting them).
module pwm_duty_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter logic [27:0] CLK_FREQ     = 28'd100_000000,
  parameter logic [27:0] PWM_HZ       = 28'd1000,
  parameter int unsigned STEP_PERIODS = 4
) (
  input  logic                 sys_clk_in,
  input  logic                 reset,
  pwm_duty_sequencer_if.slave  cmd,
  input  logic                 abort,
  output logic [7:0]           duty_percentage,
  output logic                 period_start,
  output logic                 busy,
  output logic                 done,
  output logic                 cmd_err,
  output seq_state_e           state_dbg
);

  localparam logic [7:0] STEP_EFF = (STEP_PERIODS == 0) ? 8'd1 : 8'(STEP_PERIODS);

  seq_state_e state_q, state_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] target_q, target_d;
  logic [7:0] step_q, step_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       accept;
  logic [7:0] req_target;
  logic       req_bad;
  logic [7:0] step_inc;
  logic [7:0] duty_step;

  period_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .PWM_HZ   (PWM_HZ)
  ) u_tick (
    .sys_clk_in   (sys_clk_in),
    .reset        (reset),
    .period_start (period_start)
  );

  assign accept = cmd.cmd_valid && (state_q == IDLE);

`ifdef DUTY_CLAMP_EN
  assign req_target = (cmd.cmd_target > MAX_DUTY) ? MAX_DUTY : cmd.cmd_target;
  assign req_bad    = 1'b0;
`else
  assign req_target = cmd.cmd_target;
  assign req_bad    = (cmd.cmd_target > MAX_DUTY);
`endif

  // Only used while duty != target, so a single step cannot overshoot or leave 0..100.
  assign step_inc  = step_q + 8'd1;
  assign duty_step = (target_q > duty_q) ? duty_q + 8'd1 : duty_q - 8'd1;

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = req_target;
          step_d   = 8'd0;
          if (req_bad)                  err_d   = 1'b1;
          else if (req_target == duty_q) done_d  = 1'b1;
          else if (cmd.cmd_immediate)    state_d = ALIGN;
          else                           state_d = RAMP;
        end
      end
      ALIGN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (period_start) begin
          duty_d  = target_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (period_start) begin
          if (step_inc >= STEP_EFF) begin
            step_d = 8'd0;
            duty_d = duty_step;
            if (duty_step == target_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            step_d = step_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      duty_q   <= 8'd0;
      target_q <= 8'd0;
      step_q   <= 8'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd.cmd_ready    = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign cmd_err          = err_q;
  assign duty_percentage  = duty_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: 10-cycle PWM period, 2 period ends per ramp step.
module tb_pwm_duty_sequencer;
  import pwm_ctrl_pkg::*;

  localparam int PC   = 10;
  localparam int STEP = 2;

  logic       sys_clk_in = 1'b0;
  logic       reset      = 1'b1;
  logic       abort      = 1'b0;
  logic [7:0] duty_percentage;
  logic       period_start;
  logic       busy;
  logic       done;
  logic       cmd_err;
  seq_state_e state_dbg;

  pwm_duty_sequencer_if cmd_if();

  pwm_duty_sequencer #(
    .CLK_FREQ     (28'd1000),
    .PWM_HZ       (28'd100),
    .STEP_PERIODS (STEP)
  ) dut (
    .sys_clk_in      (sys_clk_in),
    .reset           (reset),
    .cmd             (cmd_if.slave),
    .abort           (abort),
    .duty_percentage (duty_percentage),
    .period_start    (period_start),
    .busy            (busy),
    .done            (done),
    .cmd_err         (cmd_err),
    .state_dbg       (state_dbg)
  );

  // clock / reset-relative cycle index
  always #5 sys_clk_in = ~sys_clk_in;

  int k;
  always @(posedge sys_clk_in or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int model_duty = 0;
  logic [7:0] exp_q[$];

  function automatic bit is_end(input int c);
    return (c % PC) == (PC - 1);
  endfunction

  // driver + reference model for one command; called and returns at a negedge
  task automatic do_cmd(input string name, input int tgt, input bit imm,
                        input int abort_delay, input int abort_duty);
    int  k_a, eff, start, ends, exp_duty, done_cycle, stop_cycle, waited;
    bit  err, active, abort_now, finished;
    logic [7:0] popped;
    waited = 0;
    while (cmd_if.cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge sys_clk_in);
      waited++;
    end
    if (waited >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL %s ready_wait: cmd_ready never rose", name);
      return;
    end
    cmd_if.cmd_valid     = 1'b1;
    cmd_if.cmd_target    = 8'(tgt);
    cmd_if.cmd_immediate = imm;
    abort                = (abort_delay == 0);
    k_a = k;
    @(posedge sys_clk_in);
    #1;
    cmd_if.cmd_valid = 1'b0;
    abort            = 1'b0;

    eff = tgt;
    err = 1'b0;
`ifdef DUTY_CLAMP_EN
    if (eff > 100) eff = 100;
`else
    if (tgt > 100) err = 1'b1;
`endif
    start = model_duty;

    if (err) begin
      @(negedge sys_clk_in);
      n_tests++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL %s err_pulse got %b exp 1", name, cmd_err); end
      n_tests++; if (duty_percentage !== 8'(start)) begin n_fail++; $display("FAIL %s err_duty got %0d exp %0d", name, duty_percentage, start); end
      n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s err_ready got %b exp 1", name, cmd_if.cmd_ready); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s err_done got %b exp 0", name, done); end
      @(negedge sys_clk_in);
      n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL %s err_width got %b exp 0", name, cmd_err); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s err_busy got %b exp 0", name, busy); end
      return;
    end

    exp_q.push_back(8'(eff));

    if (eff == start) begin
      @(negedge sys_clk_in);
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s noop_done got %b exp 1", name, done); end
      n_tests++; if (duty_percentage !== 8'(start)) begin n_fail++; $display("FAIL %s noop_duty got %0d exp %0d", name, duty_percentage, start); end
      n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s noop_ready got %b exp 1", name, cmd_if.cmd_ready); end
      if (done === 1'b1) popped = exp_q.pop_front();
      else void'(exp_q.pop_back());
      @(negedge sys_clk_in);
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s noop_width got %b exp 0", name, done); end
      return;
    end

    ends = 0; exp_duty = start; active = 1'b1;
    done_cycle = -1; stop_cycle = -1; finished = 1'b0;
    for (int it = 0; it < 5000; it++) begin
      @(negedge sys_clk_in);
      n_tests++; if (duty_percentage !== 8'(exp_duty)) begin n_fail++; $display("FAIL %s duty c=%0d got %0d exp %0d", name, k, duty_percentage, exp_duty); end
      n_tests++; if (done !== (k == done_cycle)) begin n_fail++; $display("FAIL %s done c=%0d got %b exp %b", name, k, done, (k == done_cycle)); end
      n_tests++; if (busy !== active) begin n_fail++; $display("FAIL %s busy c=%0d got %b exp %b", name, k, busy, active); end
      n_tests++; if (cmd_if.cmd_ready !== !active) begin n_fail++; $display("FAIL %s ready c=%0d got %b exp %b", name, k, cmd_if.cmd_ready, !active); end
      n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL %s cmd_err c=%0d got %b exp 0", name, k, cmd_err); end
      n_tests++; if (period_start !== is_end(k)) begin n_fail++; $display("FAIL %s period_start c=%0d got %b exp %b", name, k, period_start, is_end(k)); end
      if (done === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s sb_done unexpected done, got duty %0d", name, duty_percentage);
        end else begin
          popped = exp_q.pop_front();
          if (duty_percentage !== popped) begin n_fail++; $display("FAIL %s sb_duty got %0d exp %0d", name, duty_percentage, popped); end
        end
      end
      if (stop_cycle >= 0 && k >= stop_cycle) begin
        finished = 1'b1;
        break;
      end
      abort_now = 1'b0;
      if (active) begin
        abort_now = (abort_delay > 0 && k == k_a + abort_delay) ||
                    (abort_duty >= 0 && exp_duty == abort_duty);
        if (abort_now) begin
          active = 1'b0; stop_cycle = k + 1;
          void'(exp_q.pop_back());
        end else if (is_end(k)) begin
          if (imm) begin
            exp_duty = eff; active = 1'b0; done_cycle = k + 1; stop_cycle = k + 1;
          end else begin
            ends++;
            if (ends % STEP == 0) begin
              exp_duty = (eff > exp_duty) ? exp_duty + 1 : exp_duty - 1;
              if (exp_duty == eff) begin
                active = 1'b0; done_cycle = k + 1; stop_cycle = k + 1;
              end
            end
          end
        end
      end
      abort = abort_now;
    end
    abort = 1'b0;
    if (!finished) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: duty %0d exp %0d", name, duty_percentage, exp_duty);
    end
    model_duty = exp_duty;
  endtask

  task automatic test_reset();
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_target = 8'd0; cmd_if.cmd_immediate = 1'b0;
    abort = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge sys_clk_in);
    n_tests++; if (duty_percentage !== 8'd0) begin n_fail++; $display("FAIL rst_duty got %0d exp 0", duty_percentage); end
    n_tests++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL rst_period_start got %b exp 0", period_start); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
    n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_err got %b exp 0", cmd_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", cmd_if.cmd_ready); end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk_in);
      n_tests++; if (period_start !== is_end(k)) begin n_fail++; $display("FAIL idle_period_start c=%0d got %b exp %b", k, period_start, is_end(k)); end
      n_tests++; if (duty_percentage !== 8'd0) begin n_fail++; $display("FAIL idle_duty c=%0d got %0d exp 0", k, duty_percentage); end
      n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready c=%0d got %b exp 1", k, cmd_if.cmd_ready); end
    end
    model_duty = 0;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_ramp();
    int tgt;
    tgt = (model_duty > 50) ? 0 : 100;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 8'(tgt); cmd_if.cmd_immediate = 1'b0;
    @(posedge sys_clk_in);
    #1 cmd_if.cmd_valid = 1'b0;
    repeat (45) @(negedge sys_clk_in);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (duty_percentage !== 8'd0) begin n_fail++; $display("FAIL mid_rst_duty got %0d exp 0", duty_percentage); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 1", cmd_if.cmd_ready); end
    n_tests++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_period_start got %b exp 0", period_start); end
    @(negedge sys_clk_in);
    reset = 1'b1;
    model_duty = 0;
    exp_q.delete();
    for (int i = 0; i < 25; i++) begin
      @(negedge sys_clk_in);
      n_tests++; if (period_start !== is_end(k)) begin n_fail++; $display("FAIL mid_restart_period_start c=%0d got %b exp %b", k, period_start, is_end(k)); end
      n_tests++; if (duty_percentage !== 8'd0) begin n_fail++; $display("FAIL mid_restart_duty c=%0d got %0d exp 0", k, duty_percentage); end
    end
  endtask

  task automatic test_boundaries();
    do_cmd("to2", 2, 1'b1, -1, -1);
    do_cmd("ramp_to0", 0, 1'b0, -1, -1);
    do_cmd("to99", 99, 1'b1, -1, -1);
    do_cmd("ramp_to100", 100, 1'b0, -1, -1);
    do_cmd("tgt101_at100", 101, 1'b0, -1, -1);
    do_cmd("imm_abort_on_tick", 50, 1'b1, 9, -1);
  endtask

  task automatic test_random();
    int tgt, ad, d;
    bit imm;
    for (int i = 0; i < 20; i++) begin
      imm = 1'($urandom_range(0, 1));
      if (imm || $urandom_range(0, 4) == 0) begin
        tgt = $urandom_range(0, 110);
      end else begin
        d = $urandom_range(0, 8) - 4;
        tgt = model_duty + d;
        if (tgt < 0) tgt = 0;
        if (tgt > 100) tgt = 100;
      end
      ad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
      do_cmd("random", tgt, imm, ad, -1);
    end
  endtask

  initial begin
    test_reset();
    do_cmd("imm40", 40, 1'b1, -1, -1);
    do_cmd("ramp43", 43, 1'b0, -1, -1);
    do_cmd("abort_at40", 30, 1'b0, -1, 40);
    do_cmd("tgt150", 150, 1'b0, -1, -1);
    do_cmd("noop", model_duty, 1'b0, -1, -1);
    do_cmd("noop_abort_idle", model_duty, 1'b1, 0, -1);
    do_cmd("cmd_with_idle_abort", (model_duty + 3) % 101, 1'b0, 0, -1);
    test_boundaries();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d entries exp 0", exp_q.size()); end
    test_reset_mid_ramp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
